debounce_bank: RTL
==================

# debounce_bank

Parametrised multi-channel push-button conditioner for the audio recorder front panel. It replaces the single-button debouncer. For each of N mechanical inputs it provides:
- a two-flop synchroniser,
- a stable-time debouncer with a configurable period,
- registered single-cycle edge pulses,
- a new long-press (hold) detector that fires once per press.

It sits between the board pins and the recorder control FSM.

## Interface
Parameters:
- `N`, 4, number of independent button channels.
- `DB_BITS`, 19, debounce counter width; the input must disagree with the current state for 2^DB_BITS consecutive cycles before the state toggles (5.24 ms at 100 MHz).
- `HOLD_BITS`, 27, hold counter width; a press is "long" after 2^HOLD_BITS cycles (1.34 s at 100 MHz).
- `ACTIVE_LOW`, 1, 1: pressed = debounced level 0; 0: pressed = level 1.
- `RESET_STATE`, 1, level loaded into the synchronisers and `o_state` at reset (set equal to the released pin level).

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `i_btn`  in  N  raw asynchronous button pins.
- `o_state`  out  N  debounced level per channel.
- `o_ondn`  out  N  1-cycle pulse when `o_state[i]` falls to 0.
- `o_onup`  out  N  1-cycle pulse when `o_state[i]` rises to 1.
- `o_hold`  out  N  1-cycle pulse when channel i has been continuously pressed for 2^HOLD_BITS cycles.
- `o_held`  out  N  level: channel i is pressed and its long-press has fired; clears on release.

## Operation
- Channels are fully independent; there is no cross-channel arbitration. Any mix of pulses may assert in the same cycle.
- Sync: `s0 <= i_btn[i]`, `s1 <= s0`. Only `s1` feeds the logic.
- Debounce counter `dc` (DB_BITS wide):
  - `s1 == o_state`: `dc <= 0`.
  - Otherwise: `dc <= dc + 1`. When `dc` is all-ones in that cycle, `o_state` toggles and `dc` wraps to 0.
  - Any single cycle of agreement restarts the count, so a glitch shorter than the period never changes the state.
- Edge pulses are registered and assert in the same cycle `o_state` shows its new value:
  - `o_ondn` for a new value of 0.
  - `o_onup` for a new value of 1.
  - They are never asserted together on one channel.
- pressed = `o_state ^ ACTIVE_LOW`.
- Hold counter `hc` (HOLD_BITS wide):
  - Held at 0 while not pressed.
  - Increments while pressed and `o_held == 0`.
  - When `hc` is all-ones: `o_hold` pulses for one cycle, `o_held` sets, and `hc` stops (saturates).
  - On release (the `o_state` transition to not-pressed): `hc <= 0` and `o_held <= 0` in the same cycle as the release edge pulse.
- Each press yields at most one `o_hold`. There is no auto-repeat.
- Reset, at any time including mid-count:
  - `s0`, `s1`, `o_state` <= RESET_STATE.
  - `dc`, `hc` <= 0.
  - `o_ondn`, `o_onup`, `o_hold`, `o_held` <= 0.
  - No edge pulse is generated by reset itself or on the first cycle after it.

## Timing
- Pin change to `o_state` change: 2 sync edges + 2^DB_BITS edges, provided the pin stays stable.
- Edge pulse: coincident with the `o_state` update, width exactly 1 cycle.
- Press pulse to `o_hold`: 2^HOLD_BITS cycles after the cycle `o_state` first shows pressed.
- A release exactly in the cycle `hc` hits all-ones is resolved by the release: no `o_hold`, because the release takes priority.
- Counters never overflow into a wrong state: `dc` wraps only together with the toggle, and `hc` saturates.

## Structure
- Shared package `debounce_pkg`:
  - default constants `DB_BITS_100M = 19` and `HOLD_BITS_100M = 27`;
  - helper function `cycles_to_bits(ms, clk_hz)`.
- One natural sub-module, `debounce_chan`:
  - a single channel (sync, `dc`, `hc`, pulse registers) with scalar ports;
  - instantiated N times in a generate loop by `debounce_bank`.
- The top level contains only the generate loop and vector packing.

## Test plan
Bench settings: N=2, DB_BITS=3, HOLD_BITS=5, ACTIVE_LOW=1, RESET_STATE=1.

1. Reset with `i_btn=2'b11`, then drive `i_btn[0]=0` and hold → `o_state[0]` falls exactly 10 cycles after the pin edge; `o_ondn[0]` is high for 1 cycle only, in that cycle.
2. Bounce on ch0: low 5 cycles, high 1 cycle, repeated 4 times, then steady low → no `o_state` change until 8 consecutive disagreeing cycles after the last bounce, and exactly one `o_ondn`.
3. Hold ch1 low for 60 cycles → `o_hold[1]` pulses once, 32 cycles after `o_ondn[1]`, and `o_held[1]` stays high. On release, `o_onup[1]` pulses and `o_held[1]` clears in the same cycle.
4. Release ch0 in the cycle its `hc`=31 → no `o_hold[0]`, and `o_onup[0]` still occurs.
5. Press ch0 and ch1 on the same edge → `o_ondn=2'b11` in one cycle, and both `o_hold` pulse in the same cycle.
6. Assert `rst` for 1 cycle while `dc[0]=5` and `o_held[1]=1` → all outputs are 0 except `o_state=2'b11`, and no pulse on the cycle after `rst` deasserts.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants, per-channel flag bundle and sizing helper for the button debouncer bank.
package debounce_pkg;

    localparam int unsigned DB_BITS_100M   = 19;
    localparam int unsigned HOLD_BITS_100M = 27;

    typedef struct packed {
        logic ondn;
        logic onup;
        logic hold;
        logic held;
    } chan_flags_t;

    // Counter width whose 2^bits period covers ms milliseconds at clk_hz.
    function automatic int unsigned cycles_to_bits(input int unsigned ms, input int unsigned clk_hz);
        longint unsigned cycles;
        cycles = (64'(ms) * 64'(clk_hz)) / 64'd1000;
        return 32'($clog2(cycles));
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// Single button channel: two-flop synchroniser, stable-time debouncer,
// registered edge pulses and a once-per-press long-press detector.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned DB_BITS     = DB_BITS_100M,
    parameter int unsigned HOLD_BITS   = HOLD_BITS_100M,
    parameter bit          ACTIVE_LOW  = 1'b1,
    parameter bit          RESET_STATE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_state,
    output logic o_ondn,
    output logic o_onup,
    output logic o_hold,
    output logic o_held
);

    logic                 s0_q, s1_q;
    logic                 state_q, state_d;
    logic [DB_BITS-1:0]   dc_q, dc_d;
    logic [HOLD_BITS-1:0] hc_q, hc_d;
    chan_flags_t          flags_q, flags_d;
    logic                 toggle_c;
    logic                 pressed_c;

    always_comb begin
        state_d       = state_q;
        dc_d          = '0;
        hc_d          = hc_q;
        flags_d       = '0;
        flags_d.held  = flags_q.held;
        toggle_c      = 1'b0;
        pressed_c     = state_q ^ ACTIVE_LOW;

        // Count consecutive disagreement; wrap only together with the toggle.
        if (s1_q != state_q) begin
            if (&dc_q) begin
                state_d  = ~state_q;
                toggle_c = 1'b1;
            end else begin
                dc_d = dc_q + DB_BITS'(1);
            end
        end

        flags_d.ondn = toggle_c & ~state_d;
        flags_d.onup = toggle_c &  state_d;

        // A release edge beats a hold that would fire in the same cycle.
        if (!pressed_c || toggle_c) begin
            hc_d         = '0;
            flags_d.held = 1'b0;
        end else if (!flags_q.held) begin
            if (&hc_q) begin
                flags_d.hold = 1'b1;
                flags_d.held = 1'b1;
            end else begin
                hc_d = hc_q + HOLD_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q    <= RESET_STATE;
            s1_q    <= RESET_STATE;
            state_q <= RESET_STATE;
            dc_q    <= '0;
            hc_q    <= '0;
            flags_q <= '0;
        end else begin
            s0_q    <= i_btn;
            s1_q    <= s0_q;
            state_q <= state_d;
            dc_q    <= dc_d;
            hc_q    <= hc_d;
            flags_q <= flags_d;
        end
    end

    assign o_state = state_q;
    assign o_ondn  = flags_q.ondn;
    assign o_onup  = flags_q.onup;
    assign o_hold  = flags_q.hold;
    assign o_held  = flags_q.held;

endmodule

// File: rtl/debounce_bank.sv
// N independent push-button conditioners packed onto vector ports.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned DB_BITS     = DB_BITS_100M,
    parameter int unsigned HOLD_BITS   = HOLD_BITS_100M,
    parameter bit          ACTIVE_LOW  = 1'b1,
    parameter bit          RESET_STATE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_btn,
    output logic [N-1:0] o_state,
    output logic [N-1:0] o_ondn,
    output logic [N-1:0] o_onup,
    output logic [N-1:0] o_hold,
    output logic [N-1:0] o_held
);

    for (genvar i = 0; i < N; i++) begin : g_chan
        debounce_chan #(
            .DB_BITS     (DB_BITS),
            .HOLD_BITS   (HOLD_BITS),
            .ACTIVE_LOW  (ACTIVE_LOW),
            .RESET_STATE (RESET_STATE)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (i_btn[i]),
            .o_state (o_state[i]),
            .o_ondn  (o_ondn[i]),
            .o_onup  (o_onup[i]),
            .o_hold  (o_hold[i]),
            .o_held  (o_held[i])
        );
    end

endmodule
